// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the VGA timing path.
// Defaults describe 640x480@60; coordinates and counters are VGA_CW bits wide.
package vga_timing_pkg;

    localparam int VGA_CW        = 10;
    localparam int VGA_MAX_TOTAL = 1 << VGA_CW;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic bit axis_total_ok(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp) <= VGA_MAX_TOTAL;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the pattern/colour stage.
// All members are registered and mutually aligned; consumers sample on pix_ce.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic              pix_ce;
    logic              h_sync;
    logic              v_sync;
    logic              de;
    logic [VGA_CW-1:0] x;
    logic [VGA_CW-1:0] y;
    logic              line_start;
    logic              frame_start;
    logic [7:0]        frame_cnt;

    modport master (
        output pix_ce, h_sync, v_sync, de, x, y, line_start, frame_start, frame_cnt
    );

    modport slave (
        input  pix_ce, h_sync, v_sync, de, x, y, line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational active/sync decode.
// count moves on step, clear wins over step; decodes describe the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              clear,
    output logic [VGA_CW-1:0] count,
    output logic              wrap,
    output logic              in_active,
    output logic              sync
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = ACTIVE + FP + SYNC;

    localparam logic [VGA_CW-1:0] LAST = VGA_CW'(TOTAL - 1);

    logic in_sync;

    // Compared as int so a 1024-wide axis cannot alias its end bound to 0.
    assign wrap      = (count == LAST);
    assign in_active = (int'(count) < ACTIVE);
    assign in_sync   = (int'(count) >= SYNC_START) && (int'(count) < SYNC_END);
    assign sync      = in_sync ? POL : ~POL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel divider, h/v counters, registered sync/de/coords/strobes.
// Outputs lag the counters by one clk; no backpressure, enable low parks the raster at 0,0.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV  = 1,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    vga_sync_gen_if.master vo
);

    if (!axis_total_ok(H_ACTIVE, H_FP, H_SYNC, H_BP)) begin : g_h_total_chk
        $error("vga_sync_gen: horizontal total exceeds counter range");
    end
    if (!axis_total_ok(V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_v_total_chk
        $error("vga_sync_gen: vertical total exceeds counter range");
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_pix_div_chk
        $error("vga_sync_gen: PIX_DIV out of range 1..16");
    end

    localparam logic [3:0] DC_LAST = 4'(PIX_DIV - 1);

    // Reset asserts asynchronously but releases two clk edges later.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [3:0] dc;
    logic       ce;

    assign ce = enable && (dc == DC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc <= '0;
        end else if (!enable || dc == DC_LAST) begin
            dc <= '0;
        end else begin
            dc <= dc + 4'd1;
        end
    end

    logic [VGA_CW-1:0] hc, vc;
    logic              h_wrap, v_wrap;
    logic              h_act, v_act;
    logic              h_sync_d, v_sync_d;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (ce),
        .clear     (!enable),
        .count     (hc),
        .wrap      (h_wrap),
        .in_active (h_act),
        .sync      (h_sync_d)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (ce && h_wrap),
        .clear     (!enable),
        .count     (vc),
        .wrap      (v_wrap),
        .in_active (v_act),
        .sync      (v_sync_d)
    );

    logic [7:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (ce && h_wrap && v_wrap) begin
            frame_q <= frame_q + 8'd1;
        end
    end

    logic              pix_ce_q, de_q, h_sync_q, v_sync_q;
    logic              line_start_q, frame_start_q;
    logic [VGA_CW-1:0] x_q, y_q;

    // Decode is captured only on pixel enables so it holds between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_ce_q      <= 1'b0;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            h_sync_q      <= ~H_POL;
            v_sync_q      <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_ce_q      <= ce;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (!enable) begin
                de_q     <= 1'b0;
                x_q      <= '0;
                y_q      <= '0;
                h_sync_q <= ~H_POL;
                v_sync_q <= ~V_POL;
            end else if (ce) begin
                de_q          <= h_act && v_act;
                x_q           <= hc;
                y_q           <= vc;
                h_sync_q      <= h_sync_d;
                v_sync_q      <= v_sync_d;
                line_start_q  <= (hc == '0);
                frame_start_q <= (hc == '0) && (vc == '0);
            end
        end
    end

    assign vo.pix_ce      = pix_ce_q;
    assign vo.de          = de_q;
    assign vo.x           = x_q;
    assign vo.y           = y_q;
    assign vo.h_sync      = h_sync_q;
    assign vo.v_sync      = v_sync_q;
    assign vo.line_start  = line_start_q;
    assign vo.frame_start = frame_start_q;
    assign vo.frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 line, a small 8x8 raster for frame/enable/wrap/reset,
// and a PIX_DIV=2 active-high-sync instance for divider and polarity behaviour.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset_n;
    logic en_def, en_small, en_div2;

    int checks = 0;
    int errors = 0;

    int n, de_cnt, hs_cnt, hs_first, hs_last, ce_cnt, ls_cnt, hold_bad, stab_bad;
    logic [9:0] px, py;
    logic       pde, phs;

    always #5 clk = ~clk;

    vga_sync_gen_if if_def ();
    vga_sync_gen_if if_small ();
    vga_sync_gen_if if_div2 ();

    vga_sync_gen u_def (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (en_def),
        .vo      (if_def)
    );

    vga_sync_gen #(
        .PIX_DIV (1),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (en_small),
        .vo      (if_small)
    );

    vga_sync_gen #(
        .PIX_DIV (2),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL   (1'b1), .V_POL(1'b1)
    ) u_div2 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (en_div2),
        .vo      (if_div2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        en_def   = 1'b0;
        en_small = 1'b0;
        en_div2  = 1'b0;
        repeat (3) tick();

        check("rst_pix_ce",   32'(if_small.pix_ce), 32'd0);
        check("rst_de",       32'(if_small.de), 32'd0);
        check("rst_x",        32'(if_small.x), 32'd0);
        check("rst_y",        32'(if_small.y), 32'd0);
        check("rst_frame",    32'(if_small.frame_cnt), 32'd0);
        check("rst_h_sync",   32'(if_def.h_sync), 32'd1);
        check("rst_v_sync",   32'(if_def.v_sync), 32'd1);
        check("rst_h_sync_p", 32'(if_div2.h_sync), 32'd0);

        reset_n = 1'b1;
        repeat (4) tick();
        check("idle_pix_ce", 32'(if_def.pix_ce), 32'd0);

        // Default timing, one full line.
        en_def = 1'b1;
        tick();
        check("a_pix_ce",      32'(if_def.pix_ce), 32'd1);
        check("a_frame_start", 32'(if_def.frame_start), 32'd1);
        check("a_x0",          32'(if_def.x), 32'd0);
        check("a_y0",          32'(if_def.y), 32'd0);
        check("a_de0",         32'(if_def.de), 32'd1);
        check("a_h_sync0",     32'(if_def.h_sync), 32'd1);
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ce_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (if_def.de) de_cnt++;
            if (if_def.pix_ce) ce_cnt++;
            if (if_def.line_start) ls_cnt++;
            if (!if_def.h_sync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(if_def.x);
                hs_last = int'(if_def.x);
            end
            tick();
        end
        check("a_de_count",   32'(de_cnt), 32'd640);
        check("a_hs_count",   32'(hs_cnt), 32'd96);
        check("a_hs_first",   32'(hs_first), 32'd656);
        check("a_hs_last",    32'(hs_last), 32'd751);
        check("a_ce_count",   32'(ce_cnt), 32'd800);
        check("a_ls_count",   32'(ls_cnt), 32'd1);
        check("a_line_start", 32'(if_def.line_start), 32'd1);
        check("a_line_x",     32'(if_def.x), 32'd0);
        check("a_line_y",     32'(if_def.y), 32'd1);
        check("a_line_fs",    32'(if_def.frame_start), 32'd0);
        en_def = 1'b0;
        tick();
        check("a_off_pix_ce", 32'(if_def.pix_ce), 32'd0);

        // Small 8x8 raster, one full frame.
        en_small = 1'b1;
        tick();
        check("b_frame_start", 32'(if_small.frame_start), 32'd1);
        check("b_frame_cnt0",  32'(if_small.frame_cnt), 32'd0);
        n = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; ls_cnt = 0;
        do begin
            if (if_small.de) de_cnt++;
            if (if_small.line_start) ls_cnt++;
            if (!if_small.v_sync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(if_small.y);
                hs_last = int'(if_small.y);
            end
            tick();
            n++;
        end while (!if_small.frame_start && n < 200);
        check("b_frame_period", 32'(n), 32'd64);
        check("b_vs_count",     32'(hs_cnt), 32'd16);
        check("b_vs_first",     32'(hs_first), 32'd5);
        check("b_vs_last",      32'(hs_last), 32'd6);
        check("b_de_count",     32'(de_cnt), 32'd16);
        check("b_ls_count",     32'(ls_cnt), 32'd8);
        check("b_frame_cnt1",   32'(if_small.frame_cnt), 32'd1);

        // Enable dropped inside both sync pulses, then restored.
        repeat (45) tick();
        check("c_x5",      32'(if_small.x), 32'd5);
        check("c_y5",      32'(if_small.y), 32'd5);
        check("c_hs_on",   32'(if_small.h_sync), 32'd0);
        check("c_vs_on",   32'(if_small.v_sync), 32'd0);
        en_small = 1'b0;
        tick();
        check("c_off_hs",     32'(if_small.h_sync), 32'd1);
        check("c_off_vs",     32'(if_small.v_sync), 32'd1);
        check("c_off_de",     32'(if_small.de), 32'd0);
        check("c_off_pix_ce", 32'(if_small.pix_ce), 32'd0);
        check("c_off_frame",  32'(if_small.frame_cnt), 32'd1);
        hold_bad = 0;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (if_small.pix_ce || if_small.de || if_small.line_start || if_small.frame_start ||
                !if_small.h_sync || !if_small.v_sync || if_small.frame_cnt != 8'd1 ||
                if_small.x != 10'd0 || if_small.y != 10'd0) hold_bad++;
        end
        check("c_hold", 32'(hold_bad), 32'd0);
        en_small = 1'b1;
        tick();
        check("c_restart_fs",    32'(if_small.frame_start), 32'd1);
        check("c_restart_x",     32'(if_small.x), 32'd0);
        check("c_restart_y",     32'(if_small.y), 32'd0);
        check("c_restart_frame", 32'(if_small.frame_cnt), 32'd1);

        // PIX_DIV=2 with active-high syncs.
        en_div2 = 1'b1;
        tick();
        check("d_first_ce0", 32'(if_div2.pix_ce), 32'd0);
        tick();
        check("d_first_ce1", 32'(if_div2.pix_ce), 32'd1);
        check("d_first_fs",  32'(if_div2.frame_start), 32'd1);
        check("d_hs_idle",   32'(if_div2.h_sync), 32'd0);
        check("d_vs_idle",   32'(if_div2.v_sync), 32'd0);
        n = 0; ce_cnt = 0; hs_cnt = 0; stab_bad = 0;
        do begin
            if (if_div2.pix_ce) ce_cnt++;
            if (if_div2.h_sync) hs_cnt++;
            px = if_div2.x; py = if_div2.y; pde = if_div2.de; phs = if_div2.h_sync;
            tick();
            n++;
            if (!if_div2.pix_ce && (if_div2.x != px || if_div2.y != py ||
                                    if_div2.de != pde || if_div2.h_sync != phs)) stab_bad++;
        end while (!if_div2.line_start && n < 100);
        check("d_line_clks", 32'(n), 32'd16);
        check("d_ce_count",  32'(ce_cnt), 32'd8);
        check("d_hs_high",   32'(hs_cnt), 32'd4);
        check("d_stable",    32'(stab_bad), 32'd0);
        check("d_line_y",    32'(if_div2.y), 32'd1);

        // frame_cnt wrap, then asynchronous reset mid-line at 255.
        n = 0;
        while (!(if_small.frame_cnt == 8'd255 && if_small.frame_start) && n < 20000) begin
            tick();
            n++;
        end
        check("e_cnt255", 32'(if_small.frame_cnt), 32'd255);
        n = 0;
        do begin
            tick();
            n++;
        end while (!if_small.frame_start && n < 200);
        check("e_wrap_period", 32'(n), 32'd64);
        check("e_wrap_zero",   32'(if_small.frame_cnt), 32'd0);
        n = 0;
        while (!(if_small.frame_cnt == 8'd255 && if_small.x == 10'd3 && if_small.y == 10'd2) &&
               n < 20000) begin
            tick();
            n++;
        end
        check("e_mid_x",     32'(if_small.x), 32'd3);
        check("e_mid_frame", 32'(if_small.frame_cnt), 32'd255);
        check("e_mid_de",    32'(if_small.de), 32'd1);
        reset_n = 1'b0;
        #1;
        check("e_rst_pix_ce", 32'(if_small.pix_ce), 32'd0);
        check("e_rst_de",     32'(if_small.de), 32'd0);
        check("e_rst_x",      32'(if_small.x), 32'd0);
        check("e_rst_y",      32'(if_small.y), 32'd0);
        check("e_rst_frame",  32'(if_small.frame_cnt), 32'd0);
        check("e_rst_ls",     32'(if_small.line_start), 32'd0);
        check("e_rst_hs",     32'(if_small.h_sync), 32'd1);
        check("e_rst_vs",     32'(if_small.v_sync), 32'd1);
        check("e_rst_hs_p",   32'(if_div2.h_sync), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA demo path. It divides the system clock into a pixel-rate enable and runs horizontal and vertical counters. From these it produces registered sync, display-enable, pixel-coordinate and frame/line strobes. It sits directly upstream of the pattern/colour stage, which consumes `pix_ce`, `de`, `x`, `y` and `frame_cnt` to drive the 4-bit R/G/B pins. The sync outputs go straight to the pad-side `vga_h_sync`/`vga_v_sync` nets.

## Interface
- `PIX_DIV`, 1: `clk` cycles per pixel; legal range 1–16. A value of 1 means `pix_ce` is asserted every cycle.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640/16/96/48: horizontal visible region, front porch, sync width and back porch, in pixels.
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480/10/2/33: the same four quantities vertically, in lines.
- `H_POL`, `V_POL`, defaults 0/0: asserted level of each sync. A value of 0 means active-low.
- `clk` in 1: system clock (`wb_clk_i`).
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run the raster when high. When low, the counters are held at 0.
- `pix_ce` out 1: pixel-rate clock enable, one `clk` wide.
- `h_sync`, `v_sync` out 1: sync outputs, registered.
- `de` out 1: display enable, high inside the visible region.
- `x`, `y` out 10: pixel coordinates. They are valid when `de` is high and hold the raw counter value otherwise.
- `line_start` out 1: single-`pix_ce` pulse at `hc`=0.
- `frame_start` out 1: single-`pix_ce` pulse at `hc`=0, `vc`=0.
- `frame_cnt` out 8: count of frames since reset; wraps 255→0.

## Operation
Derived totals:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).

Pixel divider:
- Counter `dc` runs 0..PIX_DIV-1.
- `pix_ce` is asserted when `dc`=PIX_DIV-1 and `enable` is high.
- When `enable` is low, `dc` is held at 0.

Horizontal counter `hc`, 10 bits:
- On `pix_ce`, `hc` wraps to 0 when it equals H_TOTAL-1 and increments otherwise.

Vertical counter `vc`, 10 bits:
- Advances only on `pix_ce` with `hc`=H_TOTAL-1.
- Wraps to 0 when it equals V_TOTAL-1 and increments otherwise.
- `frame_cnt` increments on the same event in which `vc` wraps.

Output decode (registered, computed from the counter values):
- `h_sync` is at level H_POL for H_ACTIVE+H_FP ≤ `hc` < H_ACTIVE+H_FP+H_SYNC, and at ~H_POL otherwise. `v_sync` is the same function of `vc`, using the V parameters and V_POL.
- `de` = (`hc` < H_ACTIVE) && (`vc` < V_ACTIVE).
- `x` = `hc`, `y` = `vc`.

`enable` low:
- `hc`, `vc` and `dc` are forced to 0.
- `pix_ce`, `de`, `line_start` and `frame_start` are 0.
- Both syncs are at their inactive levels.
- `frame_cnt` holds its value.

`enable` rising:
- The first `pix_ce` occurs PIX_DIV cycles later.
- The raster starts at `hc`=`vc`=0, and that first `pix_ce` carries `frame_start`.

Reset values, applied asynchronously on `reset_n` low:
- All counters are 0, and `frame_cnt` is 0.
- `pix_ce`, `de`, `line_start` and `frame_start` are 0.
- `x` and `y` are 0.
- `h_sync` = ~H_POL and `v_sync` = ~V_POL.

## Timing
- Latency: every decoded output appears one `clk` after the counter value it describes.
- The decoded outputs update in the same cycle as the registered `pix_ce`, so `pix_ce`, `de`, `x`, `y`, the syncs and the strobes are mutually aligned.
- The downstream stage samples all of them on `clk` edges where `pix_ce` is high.
- Between `pix_ce` pulses, all outputs except `pix_ce` hold their values.
- Strobes are high for exactly one `clk`, the one coincident with `pix_ce`.
- Line period is H_TOTAL·PIX_DIV `clk` cycles. Frame period is H_TOTAL·V_TOTAL·PIX_DIV `clk` cycles.
- Simultaneous horizontal and vertical wrap (`hc`=H_TOTAL-1, `vc`=V_TOTAL-1):
  - Both counters and `frame_cnt` update in a single `pix_ce`.
  - The next `pix_ce` raises `frame_start` and `line_start` together.
- `enable` dropping mid-frame takes effect on the next `clk`, and no partial strobe is emitted.
- `reset_n` asserted mid-frame forces the reset values immediately.
- Release of `reset_n` is synchronised internally with a 2-flop deassertion synchroniser. The first `pix_ce` follows the synchroniser by PIX_DIV cycles.

## Structure
- Package `vga_timing_pkg`:
  - Default 640×480@60 constants.
  - Coordinate width `VGA_CW`=10.
  - A function computing H_TOTAL/V_TOTAL.
  - An elaboration-time check that each total is ≤ 1024.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - Parameters: ACTIVE, FP, SYNC, BP, POL.
  - Inputs: `step`, `clear`.
  - Outputs: `count`, `wrap`, `in_active`, `sync`.
  - The vertical instance's `step` is `pix_ce` AND the horizontal instance's `wrap`.

## Test plan
- Reset, then `enable`=1 with PIX_DIV=1 and defaults → the first `pix_ce` carries `frame_start`=1, `x`=0, `y`=0, `de`=1; `h_sync`=`v_sync`=1 while in reset.
- Count one line → `de` high for 640 `pix_ce` and low for 160. `h_sync` is low from `x`=656 to `x`=751 inclusive (96 pixels), and the next `line_start` comes 800 `pix_ce` later.
- Run one full frame → `v_sync` is low only on `y`=490..491, `frame_start` period is 420000 `clk`, and `frame_cnt` goes 0→1.
- PIX_DIV=2 → `pix_ce` is asserted every other cycle, the line takes 1600 `clk`, and outputs are stable between enables.
- Drop `enable` at `y`=100, `x`=300 for 50 cycles, then restore → the syncs go inactive and `de`=0; `frame_cnt` holds; the raster restarts at 0,0 with `frame_start`.
- Assert `reset_n`=0 at `frame_cnt`=255, mid-line → all outputs take their reset values asynchronously. Separately, a free run from 255 wraps `frame_cnt` to 0.
